// File: rtl/sm_calc_sequencer_if.sv
// Switch/button/display bundle of the calculator sequencer.
// Handshake: res_valid is a qualifier only (no ready). res_sign/res_mag are
// meaningful to a consumer only while res_valid=1, and they stay stable for
// as long as res_valid stays high.
interface sm_calc_sequencer_if #(
  parameter int MAG_BITS = 3,
  parameter int ACC_BITS = 4
);
  logic [MAG_BITS:0]   sw_value;
  logic                sw_op;
  logic                btn_enter;
  logic                btn_clear;
  logic                res_sign;
  logic [ACC_BITS-1:0] res_mag;
  logic                res_valid;
  logic                ovf;
  logic [3:0]          state_led;
  logic [7:0]          seg;

  // The board side drives the switches and buttons and observes the results.
  modport master (
    output sw_value, sw_op, btn_enter, btn_clear,
    input  res_sign, res_mag, res_valid, ovf, state_led, seg
  );

  // The sequencer side.
  modport slave (
    input  sw_value, sw_op, btn_enter, btn_clear,
    output res_sign, res_mag, res_valid, ovf, state_led, seg
  );
endinterface

// File: rtl/sm_calc_sequencer.sv
// Switch-driven sign-magnitude calculator sequencer.
// The first enter captures A. The second enter captures B and the add/sub opcode.
// The design then spends one cycle in EXEC and holds the result in SHOW.
// In SHOW, another enter chains the next operation onto the accumulator.
// The state register is one-hot, so it also drives state_led directly.
module sm_calc_sequencer #(
  parameter int MAG_BITS    = 3,
  parameter int ACC_BITS    = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic              clk_2,
  input logic              reset_n,
  sm_calc_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    WAIT_A = 4'b0001,
    WAIT_B = 4'b0010,
    EXEC   = 4'b0100,
    SHOW   = 4'b1000
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] enter_sync;
  logic [SYNC_STAGES-1:0] clear_sync;
  logic                   enter_prev;
  logic                   clear_prev;
  logic                   enter_pulse;
  logic                   clear_pulse;

  logic                a_sign;
  logic [ACC_BITS-1:0] a_mag;
  logic                b_sign;
  logic [MAG_BITS-1:0] b_mag;
  logic                op;
  logic                acc_sign;
  logic [ACC_BITS-1:0] acc_mag;
  logic                ovf;

  // The switch operand is normalised so that a negative zero is captured as +0.
  logic [MAG_BITS-1:0] sw_mag;
  logic                sw_sign;
  logic [ACC_BITS-1:0] sw_mag_acc;
  assign sw_mag     = bus.sw_value[MAG_BITS-1:0];
  assign sw_sign    = bus.sw_value[MAG_BITS] & (sw_mag != '0);
  assign sw_mag_acc = {{(ACC_BITS-MAG_BITS){1'b0}}, sw_mag};

  // The buttons pass through a synchronizer chain and then a registered
  // rising-edge detector. Each press produces one pulse, with no auto-repeat.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      enter_sync  <= '0;
      clear_sync  <= '0;
      enter_prev  <= 1'b0;
      clear_prev  <= 1'b0;
      enter_pulse <= 1'b0;
      clear_pulse <= 1'b0;
    end else begin
      enter_sync[0] <= bus.btn_enter;
      clear_sync[0] <= bus.btn_clear;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        enter_sync[i] <= enter_sync[i-1];
        clear_sync[i] <= clear_sync[i-1];
      end
      enter_prev  <= enter_sync[SYNC_STAGES-1];
      clear_prev  <= clear_sync[SYNC_STAGES-1];
      enter_pulse <= enter_sync[SYNC_STAGES-1] & ~enter_prev;
      clear_pulse <= clear_sync[SYNC_STAGES-1] & ~clear_prev;
    end
  end

  // Sign-magnitude add/subtract with saturation.
  // The effective sign of B folds in the opcode.
  logic [ACC_BITS-1:0] b_mag_acc;
  logic [ACC_BITS:0]   sum_ext;
  logic                b_eff;
  logic                f_sign;
  logic [ACC_BITS-1:0] f_mag;
  logic                f_sat;
  assign b_mag_acc = {{(ACC_BITS-MAG_BITS){1'b0}}, b_mag};

  // Compute the EXEC result from the captured operands.
  always_comb begin
    b_eff   = b_sign ^ op;
    sum_ext = '0;
    f_sign  = 1'b0;
    f_mag   = '0;
    f_sat   = 1'b0;
    if (a_sign == b_eff) begin
      sum_ext = {1'b0, a_mag} + {1'b0, b_mag_acc};
      f_sign  = a_sign;
      if (sum_ext[ACC_BITS]) begin
        f_mag = '1;
        f_sat = 1'b1;
      end else begin
        f_mag = sum_ext[ACC_BITS-1:0];
      end
    end else if (a_mag >= b_mag_acc) begin
      f_mag  = a_mag - b_mag_acc;
      f_sign = a_sign;
    end else begin
      f_mag  = b_mag_acc - a_mag;
      f_sign = b_eff;
    end
    if (f_mag == '0) begin
      f_sign = 1'b0;
    end
  end

  // Sequencer FSM. A clear pulse overrides everything, including a
  // coincident enter.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= WAIT_A;
      a_sign   <= 1'b0;
      a_mag    <= '0;
      b_sign   <= 1'b0;
      b_mag    <= '0;
      op       <= 1'b0;
      acc_sign <= 1'b0;
      acc_mag  <= '0;
      ovf      <= 1'b0;
    end else if (clear_pulse) begin
      state    <= WAIT_A;
      acc_sign <= 1'b0;
      acc_mag  <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        WAIT_A: begin
          if (enter_pulse) begin
            a_sign <= sw_sign;
            a_mag  <= sw_mag_acc;
            state  <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (enter_pulse) begin
            b_sign <= sw_sign;
            b_mag  <= sw_mag;
            op     <= bus.sw_op;
            state  <= EXEC;
          end
        end
        EXEC: begin
          acc_sign <= f_sign;
          acc_mag  <= f_mag;
          if (f_sat) begin
            ovf <= 1'b1;
          end
          state <= SHOW;
        end
        SHOW: begin
          if (enter_pulse) begin
            a_sign <= acc_sign;
            a_mag  <= acc_mag;
            b_sign <= sw_sign;
            b_mag  <= sw_mag;
            op     <= bus.sw_op;
            state  <= EXEC;
          end
        end
        default: state <= WAIT_A;
      endcase
    end
  end

  // Display value: the live switches while entering operands, the
  // accumulator once a result exists.
  logic                disp_sign;
  logic [ACC_BITS-1:0] disp_mag;
  logic [3:0]          nib;
  logic [6:0]          glyph;

  // Select the displayed value and decode the hex glyph
  // (bit 0 = segment a, bit 6 = segment g).
  always_comb begin
    if (state == WAIT_A || state == WAIT_B) begin
      disp_sign = sw_sign;
      disp_mag  = sw_mag_acc;
    end else begin
      disp_sign = acc_sign;
      disp_mag  = acc_mag;
    end
    nib = 4'(disp_mag);
    case (nib)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  end

  assign bus.seg       = {disp_sign & (disp_mag != '0), glyph};
  assign bus.res_sign  = acc_sign;
  assign bus.res_mag   = acc_mag;
  assign bus.res_valid = (state == SHOW);
  assign bus.ovf       = ovf;
  assign bus.state_led = state;

endmodule

// File: tb/tb_sm_calc_sequencer.sv
// Directed bench for sm_calc_sequencer.
// Expected results and glyphs are hand-computed constants.
module tb_sm_calc_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sm_calc_sequencer_if #(.MAG_BITS(3), .ACC_BITS(4)) bus ();

  sm_calc_sequencer #(.MAG_BITS(3), .ACC_BITS(4), .SYNC_STAGES(2)) dut (
    .clk_2   (clk),
    .reset_n (rst_n),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [4:0] exp_q[$];

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_result(input logic s, input logic [3:0] m);
    exp_q.push_back({s, m});
  endtask

  task automatic check_result(input string tag);
    logic [4:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s: observed=no expectation expected=queued result", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, {7'b0, bus.res_valid}, 8'h01);
      chk(tag, {3'b0, bus.res_sign, bus.res_mag}, {3'b0, e});
    end
  endtask

  // ---------------- drivers ----------------
  task automatic set_sw(input logic s, input logic [2:0] m, input logic o);
    bus.sw_value = {s, m};
    bus.sw_op    = o;
    #1;
  endtask

  task automatic press(input logic e, input logic c);
    @(negedge clk);
    bus.btn_enter = e;
    bus.btn_clear = c;
    repeat (3) @(negedge clk);
    bus.btn_enter = 1'b0;
    bus.btn_clear = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_state(input logic [3:0] st, input int max, input string tag);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.state_led === st) break;
    end
    chk(tag, {4'b0, bus.state_led}, {4'b0, st});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.sw_value  = '0;
    bus.sw_op     = 1'b0;
    bus.btn_enter = 1'b0;
    bus.btn_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", {4'b0, bus.state_led}, 8'h01);
    chk("rst_valid", {7'b0, bus.res_valid}, 8'h00);
    chk("rst_sign",  {7'b0, bus.res_sign}, 8'h00);
    chk("rst_mag",   {4'b0, bus.res_mag}, 8'h00);
    chk("rst_ovf",   {7'b0, bus.ovf}, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: +3 + +2 with exact latency
    set_sw(0, 3'd3, 0);
    chk("t1_live_seg_a", bus.seg, 8'h4F);
    press(1, 0);
    chk("t1_state_wb", {4'b0, bus.state_led}, 8'h02);
    set_sw(0, 3'd2, 0);
    chk("t1_live_seg_b", bus.seg, 8'h5B);
    @(negedge clk);
    bus.btn_enter = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t1_exec_state", {4'b0, bus.state_led}, 8'h04);
    chk("t1_exec_valid", {7'b0, bus.res_valid}, 8'h00);
    @(posedge clk);
    #1;
    chk("t1_show_valid", {7'b0, bus.res_valid}, 8'h01);
    @(negedge clk);
    bus.btn_enter = 1'b0;
    repeat (4) @(negedge clk);
    expect_result(0, 4'd5);
    check_result("t1_res");
    chk("t1_seg", bus.seg, 8'h6D);
    chk("t1_ovf", {7'b0, bus.ovf}, 8'h00);

    // 2: +3 + -5 = -2
    press(0, 1);
    chk("t2_clear_state", {4'b0, bus.state_led}, 8'h01);
    set_sw(0, 3'd3, 0); press(1, 0);
    set_sw(1, 3'd5, 0); press(1, 0);
    expect_result(1, 4'd2);
    check_result("t2_res");
    chk("t2_seg", bus.seg, 8'hDB);
    chk("t2_ovf", {7'b0, bus.ovf}, 8'h00);

    // 3: -7 - +7 = -14
    press(0, 1);
    set_sw(1, 3'd7, 0); press(1, 0);
    set_sw(0, 3'd7, 1); press(1, 0);
    expect_result(1, 4'hE);
    check_result("t3_res");
    chk("t3_seg", bus.seg, 8'hF9);
    chk("t3_ovf", {7'b0, bus.ovf}, 8'h00);

    // 4: +7 + +7 = +14, chain +7 saturates to 15, then clear
    press(0, 1);
    set_sw(0, 3'd7, 0); press(1, 0);
    press(1, 0);
    expect_result(0, 4'hE);
    check_result("t4_res14");
    chk("t4_seg14", bus.seg, 8'h79);
    press(1, 0);
    expect_result(0, 4'hF);
    check_result("t4_sat");
    chk("t4_ovf_set", {7'b0, bus.ovf}, 8'h01);
    chk("t4_seg15", bus.seg, 8'h71);
    press(0, 1);
    chk("t4_clr_state", {4'b0, bus.state_led}, 8'h01);
    chk("t4_clr_mag",   {4'b0, bus.res_mag}, 8'h00);
    chk("t4_clr_ovf",   {7'b0, bus.ovf}, 8'h00);
    chk("t4_clr_valid", {7'b0, bus.res_valid}, 8'h00);

    // 5: -3 + +3 = +0, chain 0 - 5 = -5, negative zeros
    set_sw(1, 3'd4, 0);
    chk("t5_live_neg", bus.seg, 8'hE6);
    set_sw(1, 3'd3, 0); press(1, 0);
    set_sw(0, 3'd3, 0); press(1, 0);
    expect_result(0, 4'd0);
    check_result("t5_zero");
    chk("t5_seg_zero", bus.seg, 8'h3F);
    set_sw(0, 3'd5, 1); press(1, 0);
    expect_result(1, 4'd5);
    check_result("t5_chain_sub");
    chk("t5_seg_m5", bus.seg, 8'hED);
    press(0, 1);
    set_sw(1, 3'd0, 0);
    chk("t5_live_negzero", bus.seg, 8'h3F);
    press(1, 0);
    press(1, 0);
    expect_result(0, 4'd0);
    check_result("t5_negzero");

    // 6a: enter and clear together in WAIT_B -> WAIT_A
    press(0, 1);
    set_sw(0, 3'd1, 0); press(1, 0);
    chk("t6a_pre", {4'b0, bus.state_led}, 8'h02);
    press(1, 1);
    chk("t6a_state", {4'b0, bus.state_led}, 8'h01);
    chk("t6a_valid", {7'b0, bus.res_valid}, 8'h00);

    // 6b: reset while in EXEC (accumulator holds +14 beforehand)
    set_sw(0, 3'd7, 0); press(1, 0);
    press(1, 0);
    expect_result(0, 4'hE);
    check_result("t6b_pre");
    @(negedge clk);
    bus.btn_enter = 1'b1;
    wait_state(4'b0100, 10, "t6b_reach_exec");
    #1;
    rst_n = 1'b0;
    bus.btn_enter = 1'b0;
    #1;
    chk("t6b_state", {4'b0, bus.state_led}, 8'h01);
    chk("t6b_valid", {7'b0, bus.res_valid}, 8'h00);
    chk("t6b_mag",   {4'b0, bus.res_mag}, 8'h00);
    chk("t6b_sign",  {7'b0, bus.res_sign}, 8'h00);
    chk("t6b_ovf",   {7'b0, bus.ovf}, 8'h00);
    chk("t6b_seg",   bus.seg, 8'h07);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 6c: enter held 20 cycles gives one pulse only
    set_sw(0, 3'd4, 0);
    @(negedge clk);
    bus.btn_enter = 1'b1;
    repeat (20) @(negedge clk);
    bus.btn_enter = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6c_state", {4'b0, bus.state_led}, 8'h02);
    set_sw(0, 3'd1, 0); press(1, 0);
    expect_result(0, 4'd5);
    check_result("t6c_res");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Watchdog so a stuck run still terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
